// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: FSM encoding, requester IDs and
// the latched description of the access currently in flight.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Everything about the granted access that must survive after the requester's inputs change.
  typedef struct packed {
    logic port;
    logic we;
    logic oor;
  } grant_t;

  function automatic int cnt_width(input int mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the data port always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant,
  output logic port
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
    grant = if_req | d_req;
    port  = PORT_D;
    if (if_req && !d_req) begin
      port = PORT_IF;
    end
`ifdef MEM_ARB_RR_EN
    else if (if_req && d_req) begin
      port = ~last_grant;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-port word memory.
// Build option MEM_ARB_RR_EN: round-robin tie-breaking instead of data-port priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1000,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              acc_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]  DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  grant_t            cur;
  logic              pick_valid;
  logic              pick_port;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_oor;
  logic [DATA_W-1:0] rd_word;
  logic              to_resp;
`ifdef MEM_ARB_RR_EN
  logic              last_grant;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant      (pick_valid),
    .port       (pick_port)
  );

  assign sel_addr = (pick_port == PORT_D) ? d_addr : if_addr;
  assign sel_we   = (pick_port == PORT_D) && d_we;
  assign sel_oor  = {1'b0, sel_addr} >= DEPTH;

  // Out-of-range reads never touched the memory, so they return zero instead of bus garbage.
  assign rd_word  = cur.oor ? '0 : mem_rdata;

  assign to_resp  = ((state == ST_ACCESS) && cur.we) ||
                    ((state == ST_WAIT) && (cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur       <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      acc_err   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= PORT_IF;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      acc_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_ACCESS;
            cur      <= '{port: pick_port, we: sel_we, oor: sel_oor};
            mem_addr <= sel_addr;
            if (pick_port == PORT_D) begin
              mem_wdata <= d_wdata;
            end
            mem_en   <= !sel_oor;
            mem_we   <= sel_we && !sel_oor;
`ifdef MEM_ARB_RR_EN
            last_grant <= pick_port;
`endif
          end
        end
        ST_ACCESS: begin
          if (cur.we) begin
            state <= ST_RESP;
          end else begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            if (cur.port == PORT_D) begin
              d_rdata <= rd_word;
            end else begin
              if_rdata <= rd_word;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // The ack is registered on entry to RESP, so it is high exactly for the RESP cycle.
      if (to_resp) begin
        if_ack  <= (cur.port == PORT_IF);
        d_ack   <= (cur.port == PORT_D);
        acc_err <= cur.oor;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3),
// each with a latency-accurate memory model, checked against a word-level reference model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int NI    = 2;
  localparam int DEPTH = 1000;
  localparam bit P_IF  = 1'b0;
  localparam bit P_D   = 1'b1;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
    logic        err;
    int          en_cnt;
    int          we_cnt;
    logic [15:0] en_addr;
    logic [15:0] en_wdata;
    int          stray;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        if_req    [NI];
  logic [15:0] if_addr   [NI];
  logic        if_ack    [NI];
  logic [15:0] if_rdata  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [15:0] d_addr    [NI];
  logic [15:0] d_wdata   [NI];
  logic        d_ack     [NI];
  logic [15:0] d_rdata   [NI];
  logic        acc_err   [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [15:0] mem_addr  [NI];
  logic [15:0] mem_wdata [NI];
  logic [15:0] mem_rdata [NI];

  logic [15:0] mem_arr   [NI][1024];
  logic [15:0] pipe      [NI][3];
  logic [15:0] model_mem [NI][1024];
  logic [15:0] last_if   [NI];
  logic [15:0] last_d    [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .acc_err(acc_err[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .acc_err(acc_err[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Read data is valid only MEM_LAT cycles after mem_en; every other cycle carries random junk.
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_en[k] && !mem_we[k] && mem_addr[k] < 16'd1024) pipe[k][0] <= mem_arr[k][mem_addr[k][9:0]];
      else pipe[k][0] <= 16'($urandom);
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      if (mem_en[k] && mem_we[k] && mem_addr[k] < 16'd1024) mem_arr[k][mem_addr[k][9:0]] = mem_wdata[k];
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic reset_inst(input int k);
    @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    last_if[k] = '0;
    last_d[k]  = '0;
  endtask

  // One complete handshake; lat counts cycles after the sampling edge (first cycle = 1), 0 = no ack.
  task automatic run_acc(input int k, input bit port, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, output obs_t o);
    bit mine, other;
    o.lat = 0; o.rdata = '0; o.err = 1'b0; o.en_cnt = 0; o.we_cnt = 0;
    o.en_addr = '0; o.en_wdata = '0; o.stray = 0;
    @(negedge clk);
    if (port == P_D) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        o.en_cnt++;
        o.en_addr  = mem_addr[k];
        o.en_wdata = mem_wdata[k];
      end
      if (mem_we[k]) o.we_cnt++;
      mine  = (port == P_D) ? d_ack[k] : if_ack[k];
      other = (port == P_D) ? if_ack[k] : d_ack[k];
      if (other || (acc_err[k] && !mine)) o.stray++;
      if (mine) begin
        o.lat   = c;
        o.rdata = (port == P_D) ? d_rdata[k] : if_rdata[k];
        o.err   = acc_err[k];
        break;
      end
    end
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if ({if_ack[k], d_ack[k], acc_err[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], if_rdata[k], d_rdata[k]} !== '0) begin
        bad++; $display("FAIL reset_outputs[%0d]: got %h want all zero", k,
          {if_ack[k], d_ack[k], acc_err[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], if_rdata[k], d_rdata[k]});
      end
      rst[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if ({if_ack[k], d_ack[k], acc_err[k], mem_en[k], mem_we[k]} !== 5'b0) begin
        bad++; $display("FAIL idle_quiet[%0d]: got %b want 00000", k, {if_ack[k], d_ack[k], acc_err[k], mem_en[k], mem_we[k]});
      end
    end
  endtask

  task automatic test_fetch_read();
    obs_t o;
    run_acc(0, P_IF, 1'b0, 16'd5, 16'h0, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", o.lat); end
    total++; if (o.rdata !== 16'hA5A5) begin bad++; $display("FAIL fetch_rdata: got %h want a5a5", o.rdata); end
    total++; if (o.err !== 1'b0) begin bad++; $display("FAIL fetch_acc_err: got %b want 0", o.err); end
    total++; if (o.en_cnt !== 1 || o.en_addr !== 16'd5) begin
      bad++; $display("FAIL fetch_mem_en: got %0d pulses addr %0d want 1 pulse addr 5", o.en_cnt, o.en_addr);
    end
    total++; if (o.we_cnt !== 0 || o.stray !== 0) begin
      bad++; $display("FAIL fetch_side: got we=%0d stray=%0d want 0 0", o.we_cnt, o.stray);
    end
    last_if[0] = 16'hA5A5;
  endtask

  task automatic test_write();
    obs_t o;
    run_acc(0, P_D, 1'b1, 16'd10, 16'h1234, o);
    total++; if (o.lat !== 2) begin bad++; $display("FAIL write_latency: got %0d want 2", o.lat); end
    total++; if (o.en_cnt !== 1 || o.we_cnt !== 1) begin
      bad++; $display("FAIL write_strobes: got en=%0d we=%0d want 1 1", o.en_cnt, o.we_cnt);
    end
    total++; if (o.en_addr !== 16'd10 || o.en_wdata !== 16'h1234) begin
      bad++; $display("FAIL write_bus: got addr %0d data %h want 10 1234", o.en_addr, o.en_wdata);
    end
    total++; if (o.err !== 1'b0) begin bad++; $display("FAIL write_acc_err: got %b want 0", o.err); end
    model_mem[0][10] = 16'h1234;
    run_acc(0, P_D, 1'b0, 16'd10, 16'h0, o);
    total++; if (o.rdata !== 16'h1234 || o.lat !== 3) begin
      bad++; $display("FAIL write_readback: got %h lat %0d want 1234 lat 3", o.rdata, o.lat);
    end
    last_d[0] = 16'h1234;
    total++; if (if_rdata[0] !== last_if[0]) begin
      bad++; $display("FAIL fetch_rdata_hold: got %h want %h", if_rdata[0], last_if[0]);
    end
  endtask

  task automatic test_out_of_range();
    obs_t o;
    run_acc(0, P_D, 1'b0, 16'd1000, 16'h0, o);
    total++; if (o.en_cnt !== 0 || o.we_cnt !== 0) begin
      bad++; $display("FAIL oor_read_strobes: got en=%0d we=%0d want 0 0", o.en_cnt, o.we_cnt);
    end
    total++; if (o.rdata !== 16'h0 || o.err !== 1'b1 || o.lat !== 3) begin
      bad++; $display("FAIL oor_read_resp: got data %h err %b lat %0d want 0000 1 3", o.rdata, o.err, o.lat);
    end
    last_d[0] = '0;
    run_acc(0, P_D, 1'b1, 16'd1000, 16'hBEEF, o);
    total++; if (o.en_cnt !== 0 || o.we_cnt !== 0 || o.err !== 1'b1 || o.lat !== 2) begin
      bad++; $display("FAIL oor_write: got en=%0d we=%0d err=%b lat=%0d want 0 0 1 2", o.en_cnt, o.we_cnt, o.err, o.lat);
    end
    total++; if (d_rdata[0] !== last_d[0]) begin
      bad++; $display("FAIL oor_write_rdata_hold: got %h want %h", d_rdata[0], last_d[0]);
    end
    run_acc(0, P_D, 1'b0, 16'd999, 16'h0, o);
    total++; if (o.rdata !== model_mem[0][999] || o.err !== 1'b0 || o.en_cnt !== 1) begin
      bad++; $display("FAIL edge_999: got data %h err %b en %0d want %h 0 1", o.rdata, o.err, o.en_cnt, model_mem[0][999]);
    end
    last_d[0] = model_mem[0][999];
  endtask

  task automatic test_latency3();
    obs_t o;
    logic [15:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom_range(0, DEPTH - 1));
      run_acc(1, (i == 1) ? P_IF : P_D, 1'b0, a, 16'h0, o);
      total++; if (o.lat !== 5) begin bad++; $display("FAIL lat3_latency%0d: got %0d want 5", i, o.lat); end
      total++; if (o.rdata !== model_mem[1][a[9:0]]) begin
        bad++; $display("FAIL lat3_rdata%0d: got %h want %h", i, o.rdata, model_mem[1][a[9:0]]);
      end
      if (i == 1) last_if[1] = model_mem[1][a[9:0]];
      else last_d[1] = model_mem[1][a[9:0]];
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [15:0] a;
    int acts;
    a = 16'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = a; d_wdata[1] = 16'($urandom);
    @(negedge clk);
    total++; if ({mem_en[1], mem_we[1]} !== 2'b11) begin
      bad++; $display("FAIL rst_pre_access: got %b want 11", {mem_en[1], mem_we[1]});
    end
    #2 rst[1] = 1'b1;
    #1;
    total++; if ({mem_en[1], mem_we[1]} !== 2'b00) begin
      bad++; $display("FAIL rst_async_access: got %b want 00", {mem_en[1], mem_we[1]});
    end
    d_req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    last_if[1] = '0;
    last_d[1]  = '0;

    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = a;
    @(negedge clk);
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1;
    total++; if ({mem_en[1], mem_we[1], if_ack[1], d_ack[1], acc_err[1]} !== 5'b0) begin
      bad++; $display("FAIL rst_async_wait: got %b want 00000", {mem_en[1], mem_we[1], if_ack[1], d_ack[1], acc_err[1]});
    end
    d_req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    acts = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ack[1] || if_ack[1] || mem_en[1]) acts++;
    end
    total++; if (acts !== 0) begin bad++; $display("FAIL rst_abandon: got %0d active cycles want 0", acts); end
    run_acc(1, P_D, 1'b0, a, 16'h0, o);
    total++; if (o.lat !== 5 || o.rdata !== model_mem[1][a[9:0]] || o.en_cnt !== 1) begin
      bad++; $display("FAIL rst_reissue: got lat %0d data %h en %0d want 5 %h 1", o.lat, o.rdata, o.en_cnt, model_mem[1][a[9:0]]);
    end
    last_d[1] = model_mem[1][a[9:0]];
  endtask

  task automatic test_tie();
    int ord[$];
    bit last, exp_w;
    logic [15:0] a_if, a_d;
    reset_inst(0);
    a_if = 16'($urandom_range(0, 499));
    a_d  = 16'($urandom_range(500, DEPTH - 1));
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = a_if;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = a_d;
    for (int c = 0; c < 60 && ord.size() < 4; c++) begin
      @(negedge clk);
      if (d_ack[0]) begin
        ord.push_back(1);
        last_d[0] = model_mem[0][a_d[9:0]];
        total++; if (d_rdata[0] !== last_d[0]) begin bad++; $display("FAIL tie_d_rdata: got %h want %h", d_rdata[0], last_d[0]); end
        total++; if (if_rdata[0] !== last_if[0]) begin bad++; $display("FAIL tie_if_hold: got %h want %h", if_rdata[0], last_if[0]); end
      end
      if (if_ack[0]) begin
        ord.push_back(0);
        last_if[0] = model_mem[0][a_if[9:0]];
        total++; if (if_rdata[0] !== last_if[0]) begin bad++; $display("FAIL tie_if_rdata: got %h want %h", if_rdata[0], last_if[0]); end
        total++; if (d_rdata[0] !== last_d[0]) begin bad++; $display("FAIL tie_d_hold: got %h want %h", d_rdata[0], last_d[0]); end
      end
    end
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    total++; if (ord.size() != 4) begin bad++; $display("FAIL tie_count: got %0d acks want 4", ord.size()); end
    last = P_IF;
    for (int i = 0; i < 4; i++) begin
      exp_w = RR ? !last : P_D;
      last  = exp_w;
      if (i < ord.size()) begin
        total++;
        if (ord[i] != int'(exp_w)) begin bad++; $display("FAIL tie_order%0d: got port %0d want port %0d", i, ord[i], exp_w); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      obs_t o;
      int k, exp_lat;
      bit port, we, oor;
      logic [15:0] addr, wd, exp_rd, hold_exp, hold_got;
      k    = $urandom_range(0, 1);
      port = 1'($urandom_range(0, 1));
      we   = (port == P_D) ? 1'($urandom_range(0, 1)) : 1'b0;
      case ($urandom_range(0, 5))
        0:       addr = 16'd999;
        1:       addr = 16'd1000;
        2:       addr = 16'($urandom_range(1000, 1023));
        default: addr = 16'($urandom_range(0, DEPTH - 1));
      endcase
      wd      = 16'($urandom);
      oor     = (addr >= 16'(DEPTH));
      exp_lat = we ? 2 : lat_of(k) + 2;
      exp_rd  = we ? last_d[k] : (oor ? 16'h0 : model_mem[k][addr[9:0]]);
      run_acc(k, port, we, addr, wd, o);
      total++; if (o.lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.lat, exp_lat); end
      total++; if (o.rdata !== exp_rd || o.err !== oor) begin
        bad++; $display("FAIL rnd%0d_resp: got data %h err %b want %h %b", i, o.rdata, o.err, exp_rd, oor);
      end
      total++; if (o.en_cnt !== (oor ? 0 : 1) || o.we_cnt !== ((we && !oor) ? 1 : 0) || o.stray !== 0) begin
        bad++; $display("FAIL rnd%0d_strobes: got en=%0d we=%0d stray=%0d want %0d %0d 0", i, o.en_cnt, o.we_cnt, o.stray,
          oor ? 0 : 1, (we && !oor) ? 1 : 0);
      end
      if (!oor) begin
        total++; if (o.en_addr !== addr || (we && o.en_wdata !== wd)) begin
          bad++; $display("FAIL rnd%0d_bus: got addr %h data %h want %h %h", i, o.en_addr, o.en_wdata, addr, wd);
        end
      end
      hold_exp = (port == P_D) ? last_if[k] : last_d[k];
      hold_got = (port == P_D) ? if_rdata[k] : d_rdata[k];
      total++; if (hold_got !== hold_exp) begin bad++; $display("FAIL rnd%0d_loser_hold: got %h want %h", i, hold_got, hold_exp); end
      if (we && !oor) model_mem[k][addr[9:0]] = wd;
      if (!we) begin
        if (port == P_D) last_d[k] = exp_rd;
        else last_if[k] = exp_rd;
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      last_if[k] = '0; last_d[k] = '0;
      for (int a = 0; a < 1024; a++) begin
        v = 16'($urandom);
        mem_arr[k][a]   = v;
        model_mem[k][a] = v;
      end
    end
    mem_arr[0][5]   = 16'hA5A5;
    model_mem[0][5] = 16'hA5A5;

    test_reset();
    test_fetch_read();
    test_write();
    test_out_of_range();
    test_latency3();
    test_reset_mid();
    test_tie();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
